// File: rtl/data_mem_responder_if.sv
// Load/store request and response bus between the execute stage and the data memory responder.
interface data_mem_responder_if #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned DATA_WIDTH = 3
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_load;
   logic                  req_store;
   logic [XLEN-1:0]       req_addr;
   logic [DATA_WIDTH-1:0] req_width;
   logic [XLEN-1:0]       req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [XLEN-1:0]       rsp_rdata;
   logic                  rsp_error;

   modport master (
      output req_valid, req_load, req_store, req_addr, req_width, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error
   );

   modport slave (
      input  req_valid, req_load, req_store, req_addr, req_width, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_error
   );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: one load/store at a time, alignment/range checked, fixed access
// latency, byte-lane steering into a word-organised array that is never reset.
module data_mem_responder #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned DATA_WIDTH  = 3,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input logic                  clk_i,
   input logic                  rst_i,
   data_mem_responder_if.slave  bus
);
   localparam int unsigned IdxW  = $clog2(DEPTH_WORDS);
   localparam int unsigned AddrW = IdxW + 2;
   localparam int unsigned CntW  = $clog2(LATENCY + 1);
   localparam int unsigned NumB  = XLEN / 8;

   localparam logic [DATA_WIDTH-1:0] WWord  = DATA_WIDTH'(0);
   localparam logic [DATA_WIDTH-1:0] WHalf  = DATA_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] WByte  = DATA_WIDTH'(2);
   localparam logic [DATA_WIDTH-1:0] WByteU = DATA_WIDTH'(3);
   localparam logic [DATA_WIDTH-1:0] WHalfU = DATA_WIDTH'(4);
   localparam logic [XLEN:0]         MemBytes = (XLEN + 1)'(DEPTH_WORDS) << 2;

   typedef enum logic [1:0] {StIdle, StAccess, StRespond} state_e;

   state_e                state_q;
   logic [CntW-1:0]       cnt_q;
   logic [AddrW-1:0]      addr_q;
   logic [DATA_WIDTH-1:0] width_q;
   logic                  load_q;
   logic [XLEN-1:0]       wdata_q;
   logic                  req_ready_q;
   logic                  rsp_valid_q;
   logic [XLEN-1:0]       rsp_rdata_q;
   logic                  rsp_error_q;

   logic [XLEN-1:0]       mem_q [DEPTH_WORDS];

   logic                  illegal;
   logic                  is_half;
   logic                  commit;
   logic                  mem_we;
   logic [XLEN-1:0]       rd_shift;
   logic [XLEN-1:0]       rd_data;
   logic [XLEN-1:0]       wdata_sh;
   logic [NumB-1:0]       be;

   // Request legality and load/store lane steering for the captured request.
   always_comb begin
      is_half = (bus.req_width == WHalf) || (bus.req_width == WHalfU);
      illegal = (bus.req_load == bus.req_store)
             || (bus.req_width > WHalfU)
             || (is_half && bus.req_addr[0])
             || ((bus.req_width == WWord) && (bus.req_addr[1:0] != 2'b00))
             || ({1'b0, bus.req_addr} >= MemBytes);

      commit   = (state_q == StAccess) && (cnt_q == '0);
      // Reset wins over a commit in the same cycle, so the write is dropped.
      mem_we   = commit && !load_q && !rst_i;
      rd_shift = mem_q[addr_q[AddrW-1:2]] >> {addr_q[1:0], 3'b000};
      wdata_sh = wdata_q << {addr_q[1:0], 3'b000};
      rd_data  = rd_shift;
      be       = '1;
      case (width_q)
         WByte, WByteU: begin
            rd_data = {{(XLEN-8){1'b0}}, rd_shift[7:0]};
            be      = NumB'(1) << addr_q[1:0];
         end
         WHalf, WHalfU: begin
            rd_data = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
            be      = NumB'(3) << addr_q[1:0];
         end
         default: ;
      endcase
   end

   // Byte-enabled memory write; the array has no reset so contents survive rst.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < int'(NumB); b++) begin
         if (mem_we && be[b]) begin
            mem_q[addr_q[AddrW-1:2]][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end

   // Control FSM with registered handshake and response outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         addr_q      <= '0;
         width_q     <= '0;
         load_q      <= 1'b0;
         wdata_q     <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.req_valid) begin
                  addr_q      <= bus.req_addr[AddrW-1:0];
                  width_q     <= bus.req_width;
                  load_q      <= bus.req_load;
                  wdata_q     <= bus.req_wdata;
                  req_ready_q <= 1'b0;
                  if (illegal) begin
                     state_q     <= StRespond;
                     rsp_valid_q <= 1'b1;
                     rsp_error_q <= 1'b1;
                     rsp_rdata_q <= '0;
                  end else begin
                     state_q <= StAccess;
                     cnt_q   <= CntW'(LATENCY - 1);
                  end
               end
            end
            StAccess: begin
               if (cnt_q == '0) begin
                  state_q     <= StRespond;
                  rsp_valid_q <= 1'b1;
                  rsp_error_q <= 1'b0;
                  rsp_rdata_q <= load_q ? rd_data : '0;
               end else begin
                  cnt_q <= cnt_q - CntW'(1);
               end
            end
            StRespond: begin
               if (bus.rsp_ready) begin
                  state_q     <= StIdle;
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_error = rsp_error_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
module tb_data_mem_responder;
   localparam int unsigned Lat   = 2;
   localparam int unsigned Depth = 1024;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   data_mem_responder_if #(.XLEN(32), .DATA_WIDTH(3)) bus ();

   data_mem_responder #(
      .XLEN        (32),
      .DATA_WIDTH  (3),
      .DEPTH_WORDS (Depth),
      .LATENCY     (Lat)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request with rsp_ready high and check error, masked data and latency.
   task automatic req(input string tag, input logic ld, input logic st, input logic [31:0] addr,
                      input logic [2:0] width, input logic [31:0] wdata, input logic exp_err,
                      input logic [31:0] exp_data, input logic [31:0] mask);
      int cyc;
      check({tag, "_ready_in"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_load  = ld;
      bus.req_store = st;
      bus.req_addr  = addr;
      bus.req_width = width;
      bus.req_wdata = wdata;
      tick();
      bus.req_valid = 1'b0;
      cyc = 1;
      while (!bus.rsp_valid && cyc < 50) begin
         tick();
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), exp_err ? 32'd1 : 32'(Lat + 1));
      check({tag, "_error"}, 32'(bus.rsp_error), 32'(exp_err));
      check({tag, "_rdata"}, bus.rsp_rdata & mask, exp_data);
      tick();
      check({tag, "_ready_out"}, 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_load  = 1'b0;
      bus.req_store = 1'b0;
      bus.req_addr  = '0;
      bus.req_width = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      check("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
      rst = 1'b0;
      tick();

      // Word store/load and byte merge.
      req("st_w10", 0, 1, 32'h10, 3'd0, 32'hDEADBEEF, 0, 32'h0, 32'hFFFFFFFF);
      req("ld_w10", 1, 0, 32'h10, 3'd0, 32'h0, 0, 32'hDEADBEEF, 32'hFFFFFFFF);
      req("st_b12", 0, 1, 32'h12, 3'd2, 32'hFFFFFF5A, 0, 32'h0, 32'hFFFFFFFF);
      req("ld_w10m", 1, 0, 32'h10, 3'd0, 32'h0, 0, 32'hDE5ABEEF, 32'hFFFFFFFF);
      req("ld_b13", 1, 0, 32'h13, 3'd2, 32'h0, 0, 32'h000000DE, 32'hFFFFFFFF);
      req("ld_bu11", 1, 0, 32'h11, 3'd3, 32'h0, 0, 32'h000000BE, 32'hFFFFFFFF);

      // Halfword lanes.
      req("st_h22", 0, 1, 32'h22, 3'd1, 32'hABCD1234, 0, 32'h0, 32'hFFFFFFFF);
      req("ld_hu22", 1, 0, 32'h22, 3'd4, 32'h0, 0, 32'h00001234, 32'hFFFFFFFF);
      req("ld_w20", 1, 0, 32'h20, 3'd0, 32'h0, 0, 32'h12340000, 32'hFFFF0000);
      req("ld_h12", 1, 0, 32'h12, 3'd1, 32'h0, 0, 32'h0000DE5A, 32'hFFFFFFFF);

      // Illegal requests: immediate error response, memory untouched.
      req("err_w11", 1, 0, 32'h11, 3'd0, 32'h0, 1, 32'h0, 32'hFFFFFFFF);
      req("err_h13", 1, 0, 32'h13, 3'd1, 32'h0, 1, 32'h0, 32'hFFFFFFFF);
      req("err_range", 1, 0, 32'(Depth * 4), 3'd0, 32'h0, 1, 32'h0, 32'hFFFFFFFF);
      req("err_wid5", 0, 1, 32'h10, 3'd5, 32'h0, 1, 32'h0, 32'hFFFFFFFF);
      req("err_both", 1, 1, 32'h10, 3'd0, 32'h0, 1, 32'h0, 32'hFFFFFFFF);
      req("err_none", 0, 0, 32'h10, 3'd0, 32'h0, 1, 32'h0, 32'hFFFFFFFF);
      req("err_sth13", 0, 1, 32'h13, 3'd4, 32'hFFFF, 1, 32'h0, 32'hFFFFFFFF);
      req("ld_w10_after_err", 1, 0, 32'h10, 3'd0, 32'h0, 0, 32'hDE5ABEEF, 32'hFFFFFFFF);

      // Backpressure: hold the response, offer a store that must be ignored.
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_load  = 1'b1;
      bus.req_store = 1'b0;
      bus.req_addr  = 32'h10;
      bus.req_width = 3'd0;
      tick();
      bus.req_load  = 1'b0;
      bus.req_store = 1'b1;
      bus.req_wdata = 32'h0;
      for (int i = 0; i < Lat; i++) tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check("bp_rsp_rdata", bus.rsp_rdata, 32'hDE5ABEEF);
         check("bp_req_ready", 32'(bus.req_ready), 32'd0);
         tick();
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      tick();
      check("bp_ready_after", 32'(bus.req_ready), 32'd1);
      check("bp_valid_after", 32'(bus.rsp_valid), 32'd0);
      req("ld_w10_after_bp", 1, 0, 32'h10, 3'd0, 32'h0, 0, 32'hDE5ABEEF, 32'hFFFFFFFF);

      // Reset in the commit cycle of a store suppresses the write.
      req("st_w40_zero", 0, 1, 32'h40, 3'd0, 32'h0, 0, 32'h0, 32'hFFFFFFFF);
      bus.req_valid = 1'b1;
      bus.req_load  = 1'b0;
      bus.req_store = 1'b1;
      bus.req_addr  = 32'h40;
      bus.req_width = 3'd0;
      bus.req_wdata = 32'hFFFFFFFF;
      tick();
      bus.req_valid = 1'b0;
      for (int i = 1; i < Lat; i++) tick();
      check("rs_no_valid_yet", 32'(bus.rsp_valid), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rs_req_ready", 32'(bus.req_ready), 32'd1);
      check("rs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rs_rsp_rdata", bus.rsp_rdata, 32'd0);
      check("rs_rsp_error", 32'(bus.rsp_error), 32'd0);
      tick();
      check("rs_still_idle", 32'(bus.rsp_valid), 32'd0);
      req("ld_w40", 1, 0, 32'h40, 3'd0, 32'h0, 0, 32'h0, 32'hFFFFFFFF);
      req("ld_w10_after_rst", 1, 0, 32'h10, 3'd0, 32'h0, 0, 32'hDE5ABEEF, 32'hFFFFFFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the CPU's load/store path. The block accepts one load or store request at a time from the execute/load-store stage through a valid/ready handshake and checks alignment and range. It steers bytes into or out of a word-organised data memory that it owns, and returns one response per request after a fixed access latency. Load data comes back right-aligned and zero-filled; sign or zero extension to register width is done by the load/store formatting logic upstream.

## Interface
Parameters:
- XLEN, 32: data and address width.
- DATA_WIDTH, 3: width of the access-size code.
- DEPTH_WORDS, 1024: memory depth in XLEN-bit words. Must be a power of two.
- LATENCY, 2: number of ACCESS-state cycles. Must be ≥1.

Ports:
- clk, in, 1: clock. The only clock; all logic is on the rising edge.
- rst, in, 1: reset. Synchronous and active-high.
- req_valid, in, 1: request present.
- req_ready, out, 1: block can accept a request.
- req_load, in, 1: request is a load.
- req_store, in, 1: request is a store.
- req_addr, in, XLEN: byte address.
- req_width, in, DATA_WIDTH: access size. 0=WORD, 1=HALFWORD, 2=BYTE, 3=BYTE_UNSIGNED, 4=HALFWORD_UNSIGNED.
- req_wdata, in, XLEN: store data, right-aligned.
- rsp_valid, out, 1: response present.
- rsp_ready, in, 1: consumer accepts the response.
- rsp_rdata, out, XLEN: load data, right-aligned and zero-filled. 0 for stores and errors.
- rsp_error, out, 1: the request was rejected and memory is untouched.

## Operation
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, capture all request fields.
  - Go to RESPOND with error=1 if the request is illegal, otherwise go to ACCESS and load the counter with LATENCY-1.
- A request is illegal if any of the following holds:
  - req_load == req_store (both set or neither set).
  - req_width > 4.
  - A halfword access (code 1 or 4) with addr[0] = 1.
  - A WORD access with addr[1:0] ≠ 0.
  - addr ≥ DEPTH_WORDS*4.
- ACCESS:
  - The counter decrements each cycle.
  - In the cycle where the counter is 0, perform the memory operation and go to RESPOND.
  - Word index = addr[2 +: log2(DEPTH_WORDS)]; byte lane = addr[1:0].
- Load path:
  - BYTE / BYTE_UNSIGNED: rsp_rdata = {zeros, mem_word[8*lane +: 8]}.
  - Halfword codes: rsp_rdata = {zeros, mem_word[8*lane +: 16]}.
  - WORD: rsp_rdata = the full word.
- Store path (write only the addressed bytes; all other bytes of the word are preserved):
  - BYTE codes: write wdata[7:0] to byte `lane`.
  - Halfword codes: write wdata[15:0] to bytes `lane` and `lane+1`.
  - WORD: write the full word.
  - Stores with unsigned codes 3/4 are legal and behave like 2/1.
- RESPOND:
  - rsp_valid=1, and rsp_rdata/rsp_error are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE.
- The memory array is not reset. Contents survive rst.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, counter=0.
- Request accepted at edge E0 (req_valid && req_ready sampled high).
- Legal request:
  - ACCESS covers cycles 1..LATENCY.
  - The store commits / the load is sampled at the end of cycle LATENCY.
  - rsp_valid rises in cycle LATENCY+1.
- Illegal request: rsp_valid rises in cycle 1, and no memory access occurs.
- req_ready is 0 throughout ACCESS and RESPOND; no request is accepted while a response is pending.
- After the response handshake at edge En, req_ready=1 in cycle n+1. Minimum request spacing is LATENCY+2 cycles when rsp_ready is held high.
- Read-after-write: a load issued after a store's response has completed returns the newly stored data.
- rst has priority in every state. If rst is asserted in the commit cycle of a store, the write is suppressed. A request pending at reset is dropped with no response.
- rsp_ready low: the response is held indefinitely with no change to outputs.
- Request fields are ignored outside IDLE.

## Test plan
- Store then load, word: store WORD 0xDEADBEEF @0x10, then load WORD @0x10. Required: rsp_rdata=0xDEADBEEF, rsp_error=0, rsp_valid in cycle LATENCY+1 after accept.
- Byte merge: after the word store above, store BYTE 0x5A @0x12, then load WORD @0x10. Required: 0xDE5ABEEF. Then load BYTE @0x13. Required: 0x000000DE.
- Halfword lanes: store halfword 0x1234 @0x22, then load code 4 @0x22. Required: 0x00001234. Load WORD @0x20. Required: upper 16 bits = 0x1234.
- Errors, each requiring rsp_error=1, rsp_valid in cycle 1 after accept, and no memory change:
  - load WORD @0x11.
  - load HALFWORD @0x13.
  - addr = DEPTH_WORDS*4.
  - req_width=5.
  - req_load=req_store=1.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load. Required: rsp_valid and rsp_rdata stable, req_ready=0, and a new req_valid is ignored. Raise rsp_ready. Required: req_ready=1 on the next cycle.
- Reset mid-store: assert rst in the commit cycle of a store 0xFFFFFFFF @0x40 over old value 0x0. Required: after reset, outputs are at reset values, and a load @0x40 returns 0x0.
